cpu_addr_seq: RTL

Parametrised CPU-side address sequencer for the 4x24 GF(257) LDPC decoder. It drives NUM_CH channel memories with one address each per cycle for a single DEPTH-long load/readout pass. Each channel starts at its own programmable offset and wraps modulo DEPTH, which gives the quasi-cyclic shifted access order. It adds a start/done handshake, stall and abort on top of the plain per-channel enable counters.

---
 rtl/cpu_addr_pkg.sv | 22 ++
 rtl/cpu_addr_chan.sv | 32 +++
 rtl/cpu_addr_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_addr_pkg.sv
// Shared definitions for the CPU-side address sequencer: FSM state encoding
// and a constant-evaluable ceil(log2) helper used in parameter checks.
package cpu_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_addr_chan.sv
// One channel address counter: loads its offset (clamped to 0 when out of
// range), holds, or advances with wrap at DEPTH-1.
module cpu_addr_chan
    import cpu_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic [ADDR_WIDTH-1:0] addr
);

    // DEPTH may equal 2**ADDR_WIDTH, so the range compare needs one extra bit.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Address register: load on pass start, advance with modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= ({1'b0, offset} >= DEPTH_W) ? '0 : offset;
        end else if (advance) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_addr_seq.sv
// Address sequencer top: IDLE/RUN/DONE control with start/stall/abort,
// a pass step counter and NUM_CH shifted-offset channel counters.
module cpu_addr_seq
    import cpu_addr_pkg::*;
#(
    parameter int NUM_CH     = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         abort,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] offset,
    output logic [NUM_CH*ADDR_WIDTH-1:0] cpu_addr,
    output logic                         addr_valid,
    output logic [ADDR_WIDTH-1:0]        step,
    output logic                         busy,
    output logic                         done
);

    generate
        if (DEPTH < 2 || clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_params
            $error("cpu_addr_seq: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_STEP = ADDR_WIDTH'(DEPTH - 1);

    state_t state;
    state_t next_state;
    logic   load;
    logic   advance;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and channel control; abort outranks stall and the last step.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (stall) begin
                    next_state = ST_RUN;
                end else if (step == LAST_STEP) begin
                    next_state = ST_DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Step index within the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (load) begin
            step <= '0;
        end else if (advance) begin
            step <= step + 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_chan
            cpu_addr_chan #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DEPTH      (DEPTH)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .load    (load),
                .advance (advance),
                .offset  (offset[k*ADDR_WIDTH +: ADDR_WIDTH]),
                .addr    (cpu_addr[k*ADDR_WIDTH +: ADDR_WIDTH])
            );
        end
    endgenerate

    assign addr_valid = (state == ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE) && !abort;

endmodule
